// File: rtl/wb_interconnect_1xn.sv
// Single-master, N-slave Wishbone classic data-bus interconnect.
// The address decode is registered and latched once per transaction.
// Unmapped addresses get a bus error instead of hanging the master.
// A per-transaction watchdog forces an error on slaves that never respond.
// The first error is held in a sticky capture register until software clears it.
module wb_interconnect_1xn #(
    parameter int NUM_SLAVES     = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'h08000000, 32'h04000000},
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_MASK = {32'hFFFFFFFC, 32'hFC000000},
    parameter int TIMEOUT_CYCLES = 255,
    localparam int SEL_W         = DATA_W / 8
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_ni,
    // Master side
    input  logic [ADDR_W-1:0]            wbm_adr_i,
    input  logic [DATA_W-1:0]            wbm_dat_i,
    output logic [DATA_W-1:0]            wbm_dat_o,
    input  logic                         wbm_we_i,
    input  logic [SEL_W-1:0]             wbm_sel_i,
    input  logic                         wbm_stb_i,
    input  logic                         wbm_cyc_i,
    output logic                         wbm_ack_o,
    output logic                         wbm_err_o,
    // Slave side
    output logic [ADDR_W-1:0]            wbs_adr_o,
    output logic [DATA_W-1:0]            wbs_dat_o,
    output logic                         wbs_we_o,
    output logic [SEL_W-1:0]             wbs_sel_o,
    output logic [NUM_SLAVES-1:0]        wbs_stb_o,
    output logic [NUM_SLAVES-1:0]        wbs_cyc_o,
    input  logic [NUM_SLAVES*DATA_W-1:0] wbs_dat_i,
    input  logic [NUM_SLAVES-1:0]        wbs_ack_i,
    input  logic [NUM_SLAVES-1:0]        wbs_err_i,
    // Error capture
    output logic                         err_valid_o,
    output logic [1:0]                   err_cause_o,
    output logic [ADDR_W-1:0]            err_adr_o,
    input  logic                         err_clr_i
);

    localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TMO_LIM = CNT_W'(TIMEOUT_CYCLES);

    localparam logic [1:0] CAUSE_NONE     = 2'b00;
    localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_SLVERR   = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        ERR    = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    selIdx_q, selIdx_d;
    logic [CNT_W-1:0]    tmoCnt_q, tmoCnt_d;
    logic [ADDR_W-1:0]   reqAdr_q, reqAdr_d;
    logic                errValid_q, errValid_d;
    logic [1:0]          errCause_q, errCause_d;
    logic [ADDR_W-1:0]   errAdr_q, errAdr_d;

    logic                decHit;
    logic [IDX_W-1:0]    decIdx;
    logic [NUM_SLAVES-1:0] selOh;
    logic [DATA_W-1:0]   selDat;
    logic                selAck;
    logic                selErr;
    logic                timeoutHit;
    logic                errEvent;
    logic [1:0]          errCauseNew;

    // Address, data, we and sel go to every slave untouched; only stb/cyc are steered.
    assign wbs_adr_o = wbm_adr_i;
    assign wbs_dat_o = wbm_dat_i;
    assign wbs_we_o  = wbm_we_i;
    assign wbs_sel_o = wbm_sel_i;

    // Decode the master address against every window; scanning downwards lets the lowest index win.
    always_comb begin
        decHit = 1'b0;
        decIdx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((wbm_adr_i & SLAVE_MASK[i*ADDR_W +: ADDR_W]) == SLAVE_BASE[i*ADDR_W +: ADDR_W]) begin
                decHit = 1'b1;
                decIdx = IDX_W'(i);
            end
        end
    end

    // Mux the response signals of the latched slave; other slaves are never looked at.
    always_comb begin
        selOh  = '0;
        selDat = '0;
        selAck = 1'b0;
        selErr = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (selIdx_q == IDX_W'(i)) begin
                selOh[i] = 1'b1;
                selDat   = wbs_dat_i[i*DATA_W +: DATA_W];
                selAck   = wbs_ack_i[i];
                selErr   = wbs_err_i[i];
            end
        end
    end

    assign timeoutHit = (TIMEOUT_CYCLES != 0) && (tmoCnt_q == TMO_LIM);

    // State register plus the per-transaction bookkeeping it owns.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= IDLE;
            selIdx_q <= '0;
            tmoCnt_q <= '0;
            reqAdr_q <= '0;
        end else begin
            state_q  <= state_d;
            selIdx_q <= selIdx_d;
            tmoCnt_q <= tmoCnt_d;
            reqAdr_q <= reqAdr_d;
        end
    end

    // Next-state logic: decode in IDLE, wait for a response, abort or timeout in ACTIVE.
    always_comb begin
        state_d  = state_q;
        selIdx_d = selIdx_q;
        tmoCnt_d = tmoCnt_q;
        reqAdr_d = reqAdr_q;
        case (state_q)
            IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    reqAdr_d = wbm_adr_i;
                    if (decHit) begin
                        selIdx_d = decIdx;
                        tmoCnt_d = '0;
                        state_d  = ACTIVE;
                    end else begin
                        state_d  = ERR;
                    end
                end
            end
            ACTIVE: begin
                if (!timeoutHit) begin
                    tmoCnt_d = tmoCnt_q + 1'b1;
                end
                if (!wbm_cyc_i || timeoutHit || selAck || selErr) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output logic: steer stb/cyc to the chosen slave and form the master response.
    always_comb begin
        wbs_stb_o   = '0;
        wbs_cyc_o   = '0;
        wbm_dat_o   = '0;
        wbm_ack_o   = 1'b0;
        wbm_err_o   = 1'b0;
        errEvent    = 1'b0;
        errCauseNew = CAUSE_NONE;
        case (state_q)
            ACTIVE: begin
                wbm_dat_o = selDat;
                if (timeoutHit) begin
                    if (wbm_cyc_i) begin
                        wbm_err_o   = 1'b1;
                        errEvent    = 1'b1;
                        errCauseNew = CAUSE_TIMEOUT;
                    end
                end else begin
                    wbs_stb_o = selOh & {NUM_SLAVES{wbm_stb_i}};
                    wbs_cyc_o = selOh & {NUM_SLAVES{wbm_cyc_i}};
                    if (wbm_cyc_i) begin
                        wbm_ack_o = selAck;
                        wbm_err_o = selErr;
                        if (selErr) begin
                            errEvent    = 1'b1;
                            errCauseNew = CAUSE_SLVERR;
                        end
                    end
                end
            end
            ERR: begin
                wbm_err_o   = 1'b1;
                errEvent    = 1'b1;
                errCauseNew = CAUSE_UNMAPPED;
            end
            default: begin
            end
        endcase
    end

    // Sticky capture keeps the first error; a clear in the same cycle as a new error lets the new one in.
    always_comb begin
        errValid_d = errValid_q;
        errCause_d = errCause_q;
        errAdr_d   = errAdr_q;
        if (errEvent && (!errValid_q || err_clr_i)) begin
            errValid_d = 1'b1;
            errCause_d = errCauseNew;
            errAdr_d   = reqAdr_q;
        end else if (err_clr_i) begin
            errValid_d = 1'b0;
            errCause_d = CAUSE_NONE;
        end
    end

    // Error capture registers.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            errValid_q <= 1'b0;
            errCause_q <= CAUSE_NONE;
            errAdr_q   <= '0;
        end else begin
            errValid_q <= errValid_d;
            errCause_q <= errCause_d;
            errAdr_q   <= errAdr_d;
        end
    end

    assign err_valid_o = errValid_q;
    assign err_cause_o = errCause_q;
    assign err_adr_o   = errAdr_q;

endmodule

// File: tb/tb_wb_interconnect_1xn.sv
// Directed testbench for wb_interconnect_1xn with two slaves and an 8-cycle watchdog.
// Inputs change one time unit after the rising edge; outputs are checked on the falling edge.
module tb_wb_interconnect_1xn;

    localparam int NS = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic            clk;
    logic            rst_n;
    logic [AW-1:0]   wbm_adr;
    logic [DW-1:0]   wbm_dat_in;
    logic [DW-1:0]   wbm_dat_out;
    logic            wbm_we;
    logic [SW-1:0]   wbm_sel;
    logic            wbm_stb;
    logic            wbm_cyc;
    logic            wbm_ack;
    logic            wbm_err;
    logic [AW-1:0]   wbs_adr;
    logic [DW-1:0]   wbs_dat_out;
    logic            wbs_we;
    logic [SW-1:0]   wbs_sel;
    logic [NS-1:0]   wbs_stb;
    logic [NS-1:0]   wbs_cyc;
    logic [NS*DW-1:0] wbs_dat_in;
    logic [NS-1:0]   wbs_ack;
    logic [NS-1:0]   wbs_err;
    logic            err_valid;
    logic [1:0]      err_cause;
    logic [AW-1:0]   err_adr;
    logic            err_clr;

    int total;
    int bad;

    wb_interconnect_1xn #(
        .NUM_SLAVES     (NS),
        .ADDR_W         (AW),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_ni   (rst_n),
        .wbm_adr_i   (wbm_adr),
        .wbm_dat_i   (wbm_dat_in),
        .wbm_dat_o   (wbm_dat_out),
        .wbm_we_i    (wbm_we),
        .wbm_sel_i   (wbm_sel),
        .wbm_stb_i   (wbm_stb),
        .wbm_cyc_i   (wbm_cyc),
        .wbm_ack_o   (wbm_ack),
        .wbm_err_o   (wbm_err),
        .wbs_adr_o   (wbs_adr),
        .wbs_dat_o   (wbs_dat_out),
        .wbs_we_o    (wbs_we),
        .wbs_sel_o   (wbs_sel),
        .wbs_stb_o   (wbs_stb),
        .wbs_cyc_o   (wbs_cyc),
        .wbs_dat_i   (wbs_dat_in),
        .wbs_ack_i   (wbs_ack),
        .wbs_err_i   (wbs_err),
        .err_valid_o (err_valid),
        .err_cause_o (err_cause),
        .err_adr_o   (err_adr),
        .err_clr_i   (err_clr)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one set of master request signals.
    task automatic applyStimulus(input logic cyc, input logic stb, input logic we,
                                 input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                                 input logic [SW-1:0] sel);
        wbm_cyc    = cyc;
        wbm_stb    = stb;
        wbm_we     = we;
        wbm_adr    = adr;
        wbm_dat_in = dat;
        wbm_sel    = sel;
    endtask

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Move to the falling edge where outputs are sampled.
    task automatic sample();
        @(negedge clk);
    endtask

    // Directed test sequence.
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        err_clr = 1'b0;
        wbs_dat_in = '0;
        wbs_ack = '0;
        wbs_err = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        $display("[TB] start");

        // Reset state
        repeat (2) @(posedge clk);
        sample();
        checkOutput("rst_stb", 64'(wbs_stb), 64'h0);
        checkOutput("rst_cyc", 64'(wbs_cyc), 64'h0);
        checkOutput("rst_ack", 64'(wbm_ack), 64'h0);
        checkOutput("rst_err", 64'(wbm_err), 64'h0);
        checkOutput("rst_valid", 64'(err_valid), 64'h0);
        checkOutput("rst_cause", 64'(err_cause), 64'h0);
        checkOutput("rst_eadr", 64'(err_adr), 64'h0);
        checkOutput("rst_dat", 64'(wbm_dat_out), 64'h0);
        nextCycle();
        rst_n = 1'b1;

        // Read from slave 0 with two wait states
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h04000010, 32'h0, 4'hF);
        sample();
        checkOutput("rd_idle_stb", 64'(wbs_stb), 64'h0);
        nextCycle();
        sample();
        checkOutput("rd_c1_stb", 64'(wbs_stb), 64'h1);
        checkOutput("rd_c1_cyc", 64'(wbs_cyc), 64'h1);
        checkOutput("rd_c1_ack", 64'(wbm_ack), 64'h0);
        checkOutput("rd_adr_pass", 64'(wbs_adr), 64'h04000010);
        nextCycle();
        sample();
        checkOutput("rd_c2_stb", 64'(wbs_stb), 64'h1);
        checkOutput("rd_c2_ack", 64'(wbm_ack), 64'h0);
        nextCycle();
        wbs_dat_in = {32'h0, 32'hDEADBEEF};
        wbs_ack = 2'b01;
        sample();
        checkOutput("rd_ack", 64'(wbm_ack), 64'h1);
        checkOutput("rd_dat", 64'(wbm_dat_out), 64'hDEADBEEF);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        wbs_ack = 2'b00;
        sample();
        checkOutput("rd_after_stb", 64'(wbs_stb), 64'h0);
        checkOutput("rd_after_ack", 64'(wbm_ack), 64'h0);
        checkOutput("rd_idle_dat", 64'(wbm_dat_out), 64'h0);
        wbs_dat_in = '0;

        // Write to slave 1; a stray ack from slave 0 must be ignored
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h08000000, 32'h41, 4'b0001);
        sample();
        checkOutput("wr_idle_stb", 64'(wbs_stb), 64'h0);
        nextCycle();
        wbs_ack = 2'b01;
        sample();
        checkOutput("wr_stb", 64'(wbs_stb), 64'h2);
        checkOutput("wr_dat_pass", 64'(wbs_dat_out), 64'h41);
        checkOutput("wr_sel_pass", 64'(wbs_sel), 64'h1);
        checkOutput("wr_we_pass", 64'(wbs_we), 64'h1);
        checkOutput("wr_stray_ack", 64'(wbm_ack), 64'h0);
        nextCycle();
        wbs_ack = 2'b10;
        sample();
        checkOutput("wr_ack", 64'(wbm_ack), 64'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        wbs_ack = 2'b00;
        sample();
        checkOutput("wr_after_stb", 64'(wbs_stb), 64'h0);
        checkOutput("wr_valid", 64'(err_valid), 64'h0);

        // Unmapped access
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h10000000, '0, 4'hF);
        sample();
        checkOutput("um_req_err", 64'(wbm_err), 64'h0);
        nextCycle();
        sample();
        checkOutput("um_err", 64'(wbm_err), 64'h1);
        checkOutput("um_stb", 64'(wbs_stb), 64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        sample();
        checkOutput("um_err_once", 64'(wbm_err), 64'h0);
        checkOutput("um_valid", 64'(err_valid), 64'h1);
        checkOutput("um_cause", 64'(err_cause), 64'h1);
        checkOutput("um_eadr", 64'(err_adr), 64'h10000000);
        nextCycle();
        err_clr = 1'b1;
        nextCycle();
        err_clr = 1'b0;
        sample();
        checkOutput("clr_valid", 64'(err_valid), 64'h0);
        checkOutput("clr_cause", 64'(err_cause), 64'h0);

        // Watchdog: slave 0 never answers
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h04000000, '0, 4'hF);
        for (int k = 0; k < 8; k++) begin
            nextCycle();
            sample();
            checkOutput("tmo_wait_stb", 64'(wbs_stb), 64'h1);
            checkOutput("tmo_wait_err", 64'(wbm_err), 64'h0);
        end
        nextCycle();
        sample();
        checkOutput("tmo_err", 64'(wbm_err), 64'h1);
        checkOutput("tmo_stb", 64'(wbs_stb), 64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        sample();
        checkOutput("tmo_err_once", 64'(wbm_err), 64'h0);
        checkOutput("tmo_valid", 64'(err_valid), 64'h1);
        checkOutput("tmo_cause", 64'(err_cause), 64'h2);
        checkOutput("tmo_eadr", 64'(err_adr), 64'h04000000);

        // Second error while capture is full leaves it alone
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h20000000, '0, 4'hF);
        nextCycle();
        sample();
        checkOutput("um2_err", 64'(wbm_err), 64'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        sample();
        checkOutput("um2_cause_kept", 64'(err_cause), 64'h2);
        checkOutput("um2_eadr_kept", 64'(err_adr), 64'h04000000);
        nextCycle();
        err_clr = 1'b1;
        nextCycle();
        err_clr = 1'b0;
        sample();
        checkOutput("clr2_valid", 64'(err_valid), 64'h0);

        // Fill capture, then slave 1 error coincides with a clear
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h30000000, '0, 4'hF);
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        sample();
        checkOutput("pre_valid", 64'(err_valid), 64'h1);
        checkOutput("pre_cause", 64'(err_cause), 64'h1);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h08000002, '0, 4'hF);
        nextCycle();
        wbs_err = 2'b10;
        err_clr = 1'b1;
        sample();
        checkOutput("se_err", 64'(wbm_err), 64'h1);
        checkOutput("se_ack", 64'(wbm_ack), 64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        wbs_err = 2'b00;
        err_clr = 1'b0;
        sample();
        checkOutput("se_valid", 64'(err_valid), 64'h1);
        checkOutput("se_cause", 64'(err_cause), 64'h3);
        checkOutput("se_eadr", 64'(err_adr), 64'h08000002);
        nextCycle();
        err_clr = 1'b1;
        nextCycle();
        err_clr = 1'b0;

        // Reset asserted in the middle of an ACTIVE transaction
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h04000000, '0, 4'hF);
        nextCycle();
        sample();
        checkOutput("mr_active_stb", 64'(wbs_stb), 64'h1);
        #2;
        rst_n = 1'b0;
        wbs_ack = 2'b01;
        #1;
        checkOutput("mr_stb", 64'(wbs_stb), 64'h0);
        checkOutput("mr_cyc", 64'(wbs_cyc), 64'h0);
        checkOutput("mr_ack", 64'(wbm_ack), 64'h0);
        checkOutput("mr_err", 64'(wbm_err), 64'h0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        wbs_ack = 2'b00;
        sample();
        checkOutput("mr_valid", 64'(err_valid), 64'h0);
        checkOutput("mr_eadr", 64'(err_adr), 64'h0);
        nextCycle();
        rst_n = 1'b1;

        // Master abort: cyc drops while ACTIVE
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h04000000, '0, 4'hF);
        nextCycle();
        sample();
        checkOutput("ab_active_stb", 64'(wbs_stb), 64'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h04000000, '0, 4'hF);
        wbs_ack = 2'b01;
        sample();
        checkOutput("ab_stb", 64'(wbs_stb), 64'h0);
        checkOutput("ab_ack", 64'(wbm_ack), 64'h0);
        checkOutput("ab_err", 64'(wbm_err), 64'h0);
        nextCycle();
        wbs_ack = 2'b00;
        sample();
        checkOutput("ab_idle_ack", 64'(wbm_ack), 64'h0);
        checkOutput("ab_idle_err", 64'(wbm_err), 64'h0);
        checkOutput("ab_valid", 64'(err_valid), 64'h0);

        // Next request decodes normally with a zero-wait slave
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b1, 32'h08000000, 32'h55, 4'hF);
        nextCycle();
        wbs_ack = 2'b10;
        sample();
        checkOutput("nx_stb", 64'(wbs_stb), 64'h2);
        checkOutput("nx_ack", 64'(wbm_ack), 64'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, '0, '0);
        wbs_ack = 2'b00;
        sample();
        checkOutput("nx_after_stb", 64'(wbs_stb), 64'h0);
        checkOutput("nx_after_ack", 64'(wbm_ack), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
